display_scan: RTL and testbench
===============================

// Module: display_scan
// PURPOSE
// Reads the packed time word (hours[23:16], minutes[15:8], seconds[7:0], binary bytes) from the clock/timer core.
// Drives a 6-digit multiplexed 7-segment display: one digit per scan slot, frame-consistent snapshot.
// Blinks the field currently selected for setup; shows "--" for out-of-range bytes.
// Sits between the timekeeping counters and the board display pins.
// PARAMETERS
// CLK_HZ         50_000_000  input clock frequency
// SCAN_HZ        1000        digit slot rate; SCAN_DIV = CLK_HZ/SCAN_HZ, must be >= 2
// BLINK_HZ       2           blink rate; BLINK_HALF = CLK_HZ/(2*BLINK_HZ)
// SEG_ACT_LOW    1           1: seg outputs active-low
// DIG_ACT_LOW    1           1: dig_en outputs active-low
// PORTS
// clock        in   1   system clock
// reset        in   1   asynchronous, active-low
// enable       in   1   0: all digits off
// data         in   24  {hour,min,sec}, each an unsigned binary byte
// setup_field  in   2   0 none, 1 sec, 2 min, 3 hour: field to blink
// seg          out  8   {dp,g,f,e,d,c,b,a}
// dig_en       out  6   one-hot digit enable; bit i = slot i
// BEHAVIOUR
// - Reset: prescaler=0, idx=0, frame=0, blink_phase=0; seg and dig_en at inactive level (all segments off, no digit).
// - Prescaler counts 0..SCAN_DIV-1, then wraps. tick = (prescaler==SCAN_DIV-1).
// - On tick, idx advances 0..5, 5 wraps to 0.
//   Slots: 0 sec units, 1 sec tens, 2 min units, 3 min tens, 4 hour units, 5 hour tens.
// - Snapshot: frame <= data on the tick where idx==5 (wrap). data changes mid-frame are not shown until the next frame.
// - Digit value: byte v<=99 -> tens=v/10, units=v%10; tens digit shown even when 0.
//   v>99 -> both digits of that field show dash (segment g only).
// - dp lit on slots 2 and 4 (field separators), off elsewhere; dp follows the blanking rules.
// - Blink: counter 0..BLINK_HALF-1; blink_phase toggles at wrap.
//   When blink_phase==1 and setup_field selects field F, both slots of F output blank segments; their digit enable stays active.
//   setup_field is sampled every clock, with no latching.
// - Outputs are registered.
//   On the tick cycle dig_en goes all-inactive (1-clock anti-ghost gap).
//   The next clock drives dig_en one-hot for the new idx and seg for the new pattern.
//   Latency from tick to visible digit is 2 clocks. Each slot is lit SCAN_DIV-1 clocks.
// - enable==0: dig_en inactive on the next clock. Prescaler, idx, frame and blink keep running.
// - Polarity: internal patterns are active-high; XOR with SEG_ACT_LOW / DIG_ACT_LOW at the output register input.
// - Reset mid-scan: all state and outputs return to reset values asynchronously. After release, the scan restarts at slot 0 with frame=0.
//   The first frame shows "00 00 00" until the first wrap.
// STRUCTURE
// - display_pkg: field_t enum (FIELD_NONE, FIELD_SEC, FIELD_MIN, FIELD_HOUR).
//   Also holds SEG_DIGIT[0:9], SEG_DASH=7'h40 and SEG_BLANK=7'h00 constants.
// - Sub-module seg7_encode: 4-bit digit + dash flag -> 7-bit active-high pattern (combinational).
// - Top holds prescaler, idx, blink counter, frame register, tens/units split, and the output registers.
// TESTING (CLK_HZ=100, SCAN_HZ=10 -> SCAN_DIV=10; BLINK_HZ=1 -> BLINK_HALF=50; active-low outputs)
// - Reset asserted mid-slot 3 -> seg=8'hFF, dig_en=6'h3F immediately.
//   After release: first lit digit is slot 0 showing "0" (seg=8'hC0).
// - data=24'h17_2A_05 (23:42:05), run 2 frames.
//   Second frame slots 0..5 show 5,0,2(dp),4,3(dp),2.
//   Each slot is preceded by a 1-clock gap with dig_en=6'h3F.
// - Change data from 23:42:05 to 00:00:00 while idx==3 -> slots 3..5 still show 4,3,2.
//   The next frame shows all zeros.
// - setup_field=2 -> slots 2,3 show seg=8'hFF (blank) while blink_phase=1, i.e. for 50-clock windows.
//   They show normal digits while blink_phase=0. Other slots are unaffected.
// - data[7:0]=8'd100 -> slots 0 and 1 show dash (seg=8'hBF). Minutes and hours display normally.
// - enable=0 during slot 4 -> dig_en=6'h3F from the next clock.
//   Re-enable -> display resumes at the current idx with no glitch.

Source files
------------

// File: rtl/display_pkg.sv
// display_pkg: field codes and active-high 7-segment patterns shared by the display scanner.
package display_pkg;

    typedef enum logic [1:0] {FIELD_NONE, FIELD_SEC, FIELD_MIN, FIELD_HOUR} field_t;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg7_encode.sv
// seg7_encode: decimal digit or dash flag to an active-high {g..a} segment pattern.
module seg7_encode
    import display_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       dash,
    output logic [6:0] pattern
);

    always_comb pattern = dash ? SEG_DASH : (digit > 4'd9) ? SEG_BLANK : SEG_DIGIT[digit];

endmodule

// File: rtl/display_scan.sv
// display_scan: 6-digit multiplexed 7-segment driver for a packed {hour,min,sec} word,
// with per-frame snapshot, setup-field blinking and a one-clock anti-ghost gap per slot.
module display_scan
    import display_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int SCAN_HZ     = 1000,
    parameter int BLINK_HZ    = 2,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit DIG_ACT_LOW = 1'b1
)(
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [23:0] data,
    input  logic [1:0]  setup_field,
    output logic [7:0]  seg,
    output logic [5:0]  dig_en
);

    localparam int SCAN_DIV   = CLK_HZ / SCAN_HZ;
    localparam int BLINK_HALF = CLK_HZ / (2 * BLINK_HZ);
    localparam int PW         = $clog2(SCAN_DIV);
    localparam int BW         = BLINK_HALF > 1 ? $clog2(BLINK_HALF) : 1;

    logic [PW-1:0] prescaler;
    logic [BW-1:0] blink_cnt;
    logic [2:0]    idx;
    logic          blink_phase;
    logic [23:0]   frame;
    logic          tick;
    logic          blink_wrap;
    logic [7:0]    value;
    logic [3:0]    digit;
    logic          dash;
    logic          blank;
    field_t        field;
    logic [6:0]    pattern;
    logic [7:0]    seg_next;
    logic [5:0]    dig_next;

    seg7_encode u_encode (
        .digit   (digit),
        .dash    (dash),
        .pattern (pattern)
    );

    // Even slots carry units, odd slots tens; slot pairs map sec, min, hour.
    always_comb begin
        tick       = prescaler == PW'(SCAN_DIV - 1);
        blink_wrap = blink_cnt == BW'(BLINK_HALF - 1);
        value      = idx[2] ? frame[23:16] : idx[1] ? frame[15:8] : frame[7:0];
        field      = idx[2] ? FIELD_HOUR : idx[1] ? FIELD_MIN : FIELD_SEC;
        dash       = value > 8'd99;
        digit      = idx[0] ? 4'(value / 8'd10) : 4'(value % 8'd10);
        blank      = blink_phase && setup_field == field;
        seg_next   = (tick || blank) ? {1'b0, SEG_BLANK} : {idx == 3'd2 || idx == 3'd4, pattern};
        dig_next   = (tick || !enable) ? 6'd0 : 6'd1 << idx;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prescaler   <= '0;
            blink_cnt   <= '0;
            idx         <= '0;
            blink_phase <= 1'b0;
            frame       <= '0;
            seg         <= {8{SEG_ACT_LOW}};
            dig_en      <= {6{DIG_ACT_LOW}};
        end else begin
            prescaler   <= tick ? '0 : prescaler + 1'b1;
            blink_cnt   <= blink_wrap ? '0 : blink_cnt + 1'b1;
            blink_phase <= blink_phase ^ blink_wrap;
            if (tick) idx <= idx == 3'd5 ? 3'd0 : idx + 3'd1;
            if (tick && idx == 3'd5) frame <= data;
            seg         <= seg_next ^ {8{SEG_ACT_LOW}};
            dig_en      <= dig_next ^ {6{DIG_ACT_LOW}};
        end
    end

endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan: randomized and directed checks of display_scan against a cycle-count model
// derived from the scan/blink/snapshot rules (SCAN_DIV=10, BLINK_HALF=50, active-low outputs).
module tb_display_scan;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b1;
    logic [23:0] data = 24'h0;
    logic [1:0]  setup_field = 2'd0;
    logic [7:0]  seg;
    logic [5:0]  dig_en;

    int n_checks = 0;
    int n_fail = 0;

    localparam logic [6:0] DIGITS [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    display_scan #(
        .CLK_HZ(100), .SCAN_HZ(10), .BLINK_HZ(1), .SEG_ACT_LOW(1'b1), .DIG_ACT_LOW(1'b1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .data        (data),
        .setup_field (setup_field),
        .seg         (seg),
        .dig_en      (dig_en)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected active-low segment byte for one slot of a frame.
    function automatic logic [7:0] seg_of(input logic [23:0] f, input int slot, input bit phase,
                                          input logic [1:0] sf);
        logic [7:0] v;
        logic [7:0] pat;
        int fld;
        fld = slot / 2;
        v = f[fld*8 +: 8];
        if (phase && int'(sf) == fld + 1) return 8'hFF;
        pat = (v > 99) ? 8'h40 : {1'b0, DIGITS[(slot % 2 == 1) ? v / 10 : v % 10]};
        if (slot == 2 || slot == 4) pat = pat | 8'h80;
        return ~pat;
    endfunction

    // Model: edge k after reset release sees prescaler k%10, slot (k/10)%6, blink phase (k/50)%2.
    int          k = 0;
    logic [23:0] mframe = 24'h0;
    logic [7:0]  exp_seg = 8'hFF;
    logic [5:0]  exp_dig = 6'h3F;
    bit          seg_valid = 1'b1;

    always @(posedge clock) begin
        if (!reset) begin
            k = 0;
            mframe = 24'h0;
            exp_dig = 6'h3F;
            exp_seg = 8'hFF;
            seg_valid = 1'b1;
        end else begin
            seg_valid = 1'b0;
            exp_dig = 6'h3F;
            if (k % 10 != 9 && enable) begin
                exp_dig = ~(6'd1 << (k / 10) % 6);
                exp_seg = seg_of(mframe, (k / 10) % 6, ((k / 50) % 2) == 1, setup_field);
                seg_valid = 1'b1;
            end
            if (k % 60 == 59) mframe = data;
            k++;
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            check("model_reset_dig", {2'b0, dig_en}, 8'h3F);
            check("model_reset_seg", seg, 8'hFF);
        end else begin
            check("model_dig", {2'b0, dig_en}, {2'b0, exp_dig});
            if (seg_valid) check("model_seg", seg, exp_seg);
        end
    end

    logic [5:0] last_dig;

    task automatic wait_lit(input int slot);
        logic [5:0] want;
        want = ~(6'd1 << slot);
        for (int i = 0; i < 200; i++) begin
            last_dig = dig_en;
            @(negedge clock);
            if (dig_en === want) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL wait_slot%0d: dig_en=%h never reached %h", slot, dig_en, want);
    endtask

    logic [7:0] frame2 [6] = '{8'h92, 8'hC0, 8'h24, 8'h99, 8'h30, 8'hA4};
    logic [7:0] zeros  [6] = '{8'hC0, 8'hC0, 8'h40, 8'hC0, 8'h40, 8'hC0};

    initial begin
        int blank_cnt;
        int lit_cnt;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("first_digit_dig", {2'b0, dig_en}, 8'h3E);
        check("first_digit_seg", seg, 8'hC0);

        data = 24'h172A05;
        wait_lit(5);
        for (int s = 0; s < 6; s++) begin
            wait_lit(s);
            check("frame2_gap", {2'b0, last_dig}, 8'h3F);
            check("frame2_seg", seg, frame2[s]);
        end

        wait_lit(3);
        data = 24'h000000;
        check("snap_slot3", seg, 8'h99);
        wait_lit(4);
        check("snap_slot4", seg, 8'h30);
        wait_lit(5);
        check("snap_slot5", seg, 8'hA4);
        for (int s = 0; s < 6; s++) begin
            wait_lit(s);
            check("zero_frame", seg, zeros[s]);
        end

        data = 24'h172A64;
        wait_lit(0);
        check("dash_slot0", seg, 8'hBF);
        wait_lit(1);
        check("dash_slot1", seg, 8'hBF);
        wait_lit(2);
        check("dash_slot2", seg, 8'h24);
        wait_lit(3);
        check("dash_slot3", seg, 8'h99);

        data = 24'h172A63;
        wait_lit(0);
        check("ninety_nine_units", seg, 8'h90);
        wait_lit(1);
        check("ninety_nine_tens", seg, 8'h90);

        setup_field = 2'd2;
        blank_cnt = 0;
        lit_cnt = 0;
        for (int i = 0; i < 240; i++) begin
            @(negedge clock);
            if (dig_en == 6'h3B || dig_en == 6'h37) begin
                if (seg == 8'hFF) blank_cnt++;
                else lit_cnt++;
            end
        end
        check("blink_blank_seen", 8'(blank_cnt > 0), 8'd1);
        check("blink_lit_seen", 8'(lit_cnt > 0), 8'd1);

        wait_lit(3);
        wait_lit(4);
        enable = 1'b0;
        @(negedge clock);
        check("disable_dig", {2'b0, dig_en}, 8'h3F);
        enable = 1'b1;
        @(negedge clock);
        check("reenable_dig", {2'b0, dig_en}, 8'h2F);

        wait_lit(3);
        #2 reset = 1'b0;
        #1;
        check("async_reset_seg", seg, 8'hFF);
        check("async_reset_dig", {2'b0, dig_en}, 8'h3F);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("restart_dig", {2'b0, dig_en}, 8'h3E);
        check("restart_seg", seg, 8'hC0);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            if ($urandom_range(0, 19) == 0)
                data = {8'($urandom_range(0, 127)), 8'($urandom_range(0, 127)), 8'($urandom_range(0, 127))};
            if ($urandom_range(0, 99) == 0) setup_field = 2'($urandom_range(0, 3));
            enable = $urandom_range(0, 15) != 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
